conv_3_mac_seq: RTL

Sequencer for the shared 16x8 signed DSP multiplier in the conv_3 layer. It accepts a configured number of activation/weight pairs over a valid/ready stream and drives them through one external combinational multiplier. It accumulates the products onto a bias, then requantises the sum with an arithmetic shift. It presents one OUT_W-bit result per kernel window on a valid/ready output.

---
 rtl/conv_3_mac_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/conv_3_mac_seq.sv
// Sequencer for the shared 16x8 signed DSP multiplier of conv_3: streams act/wgt pairs into an external
// multiplier, accumulates onto a bias, requantises by arithmetic shift. Define CONV_MAC_SAT_EN to clamp instead of wrap.
module conv_3_mac_seq #(
   parameter int TAPS_W = 8,
   parameter int ACC_W  = 32,
   parameter int SHIFT  = 8,
   parameter int OUT_W  = 16
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     start,
   input  logic [TAPS_W-1:0]        cfg_taps,
   input  logic [ACC_W-1:0]         cfg_bias,
   output logic                     busy,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_act,
   input  logic [7:0]               in_wgt,
   output logic [15:0]              mul_a,
   output logic [7:0]               mul_b,
   input  logic [23:0]              mul_p,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [OUT_W-1:0]         res_data,
   output logic                     res_sat
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

   state_t                   state_q;
   logic [TAPS_W-1:0]        taps_q;
   logic [TAPS_W-1:0]        cnt_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     pvalid_q;
   logic [15:0]              mul_a_q;
   logic [7:0]               mul_b_q;
   logic                     busy_q;
   logic                     in_ready_q;
   logic                     res_valid_q;
   logic [OUT_W-1:0]         res_data_q;
   logic                     res_sat_q;

   logic                     accept;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  shifted;
   logic [OUT_W-1:0]         res_data_d;
   logic                     res_sat_d;

   assign accept   = in_valid && in_ready_q;
   assign prod_ext = ACC_W'($signed(mul_p));
   assign shifted  = acc_q >>> SHIFT;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      res_data_d = shifted[OUT_W-1:0];
      res_sat_d  = 1'b0;
`ifdef CONV_MAC_SAT_EN
      if (shifted > OUT_MAX) begin
         res_data_d = OUT_MAX[OUT_W-1:0];
         res_sat_d  = 1'b1;
      end else if (shifted < OUT_MIN) begin
         res_data_d = OUT_MIN[OUT_W-1:0];
         res_sat_d  = 1'b1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         taps_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         pvalid_q    <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_sat_q   <= 1'b0;
      end else begin
         pvalid_q <= accept;
         if (accept) begin
            mul_a_q <= in_act;
            mul_b_q <= in_wgt;
         end

         // Products land one edge after their accept; the start load never collides since pvalid is low in IDLE.
         if (state_q == S_IDLE && start)
            acc_q <= cfg_bias;
         else if (pvalid_q)
            acc_q <= acc_q + prod_ext;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  taps_q <= cfg_taps;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (cfg_taps == '0) begin
                     state_q <= S_OUT;
                  end else begin
                     state_q    <= S_RUN;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (accept) begin
                  cnt_q <= cnt_q + TAPS_W'(1);
                  if (cnt_q == taps_q - TAPS_W'(1)) begin
                     state_q    <= S_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               state_q <= S_OUT;
            end
            S_OUT: begin
               // First OUT cycle captures the settled accumulator; the result then holds until taken.
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= res_data_d;
                  res_sat_q   <= res_sat_d;
               end else if (res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign in_ready  = in_ready_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_sat   = res_sat_q;

endmodule
